// File: rtl/dm_pkg.sv
// Shared definitions for the dm_pipe data-memory block: access-size op codes and default depth.
package dm_pkg;

  localparam int DEFAULT_DEPTH = 128;

  typedef enum logic [2:0] {
    OP_W  = 3'b000,
    OP_B  = 3'b001,
    OP_BU = 3'b010,
    OP_H  = 3'b011,
    OP_HU = 3'b100
  } op_t;

endpackage

// File: rtl/dm_lane_fmt.sv
// Combinational lane formatter: store byte enables and replicated write data, misalignment check,
// and load lane extraction with sign/zero extension. No state, zero latency, no flow control.
module dm_lane_fmt
  import dm_pkg::*;
(
  input  op_t         op,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  op_t         ld_op,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] wr_word,
  output logic        misalign,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be       = 4'b1111;
    wr_word  = wdata;
    misalign = 1'b0;
    case (op)
      OP_B, OP_BU: begin
        be      = 4'b0001 << lane;
        wr_word = {4{wdata[7:0]}};
      end
      OP_H, OP_HU: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wr_word  = {2{wdata[15:0]}};
        misalign = lane[0];
      end
      default: misalign = (lane != 2'b00);
    endcase
  end

  assign ld_shift = ld_word >> {ld_lane, 3'b000};
  assign ld_byte  = ld_shift[7:0];
  assign ld_half  = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_data = ld_word;
    case (ld_op)
      OP_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_BU:   ld_data = {24'h0, ld_byte};
      OP_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      OP_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dm_pipe.sv
// Byte-addressed data memory with a one-entry response register: 1-cycle accept-to-response latency.
// req_ready drops while a response is held and unconsumed; a response stays stable until taken.
module dm_pipe
  import dm_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH) + 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  logic          alive;
  logic          accept;
  logic          wr_en;
  logic          rd_en;
  logic [AW-3:0] idx;
  logic [3:0]    be;
  logic [31:0]   wr_word;
  logic          misalign;
  logic [31:0]   ld_data;
  logic [31:0]   rd_word;
  logic          rsp_load;
  op_t           rsp_op;
  logic [1:0]    rsp_lane;

  logic [3:0][7:0] mem [DEPTH];

  // alive holds off acceptance on the edge where rstn releases
  assign req_ready = alive && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[AW-1:2];
  assign wr_en     = accept && req_we && !misalign;
  assign rd_en     = accept && !req_we;

  dm_lane_fmt u_fmt (
    .op       (op_t'(req_op)),
    .lane     (req_addr[1:0]),
    .wdata    (req_wdata),
    .ld_op    (rsp_op),
    .ld_lane  (rsp_lane),
    .ld_word  (rd_word),
    .be       (be),
    .wr_word  (wr_word),
    .misalign (misalign),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b] <= wr_word[b*8 +: 8];
      end
    end
    if (rd_en) rd_word <= mem[idx];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alive     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_load  <= 1'b0;
      rsp_op    <= OP_W;
      rsp_lane  <= 2'b00;
    end else begin
      alive <= 1'b1;
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_err   <= misalign;
        rsp_load  <= !req_we && !misalign;
        rsp_op    <= op_t'(req_op);
        rsp_lane  <= req_addr[1:0];
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        rsp_load  <= 1'b0;
      end
    end
  end

  assign rsp_rdata = rsp_load ? ld_data : 32'h0;

endmodule

// File: tb/tb_dm_pipe.sv
// Directed bench for dm_pipe: hand-computed expectations for stores, loads, misalignment,
// backpressure and reset behaviour.
module tb_dm_pipe;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  int checks = 0;
  int errors = 0;

  dm_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // One request with rsp_ready=1; returns what the response register shows just after the accept edge.
  task automatic access(input logic we, input logic [2:0] op, input logic [AW-1:0] addr,
                        input logic [31:0] wd, output logic v, output logic [31:0] d, output logic e);
    int n;
    @(negedge clk);
    req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", addr, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    v = rsp_valid; d = rsp_rdata; e = rsp_err;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", rsp_err); end
    // Request presented across the release edge must wait one more edge.
    req_we = 1'b1; req_op = 3'b000; req_addr = 9'h040; req_wdata = 32'h12345678; req_valid = 1'b1;
    #4 rstn = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL release_edge_accept got %b exp 0", rsp_valid); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL first_accept got %b exp 1", rsp_valid); end
    req_valid = 1'b0;
  endtask

  task automatic test_word();
    logic v, e; logic [31:0] d;
    access(1'b1, 3'b000, 9'h010, 32'h11223344, v, d, e);
    checks++; if ({v, e, d} !== {2'b10, 32'h0}) begin errors++; $display("FAIL word_store got v=%b e=%b d=%h exp v=1 e=0 d=0", v, e, d); end
    access(1'b0, 3'b000, 9'h010, 32'h0, v, d, e);
    checks++; if ({v, e, d} !== {2'b10, 32'h11223344}) begin errors++; $display("FAIL word_load got v=%b e=%b d=%h exp 11223344", v, e, d); end
  endtask

  task automatic test_byte();
    logic v, e; logic [31:0] d;
    access(1'b1, 3'b001, 9'h013, 32'h00000080, v, d, e);
    checks++; if ({v, e, d} !== {2'b10, 32'h0}) begin errors++; $display("FAIL byte_store got v=%b e=%b d=%h exp 0", v, e, d); end
    access(1'b0, 3'b001, 9'h013, 32'h0, v, d, e);
    checks++; if (d !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_signed got %h exp ffffff80", d); end
    access(1'b0, 3'b010, 9'h013, 32'h0, v, d, e);
    checks++; if (d !== 32'h00000080) begin errors++; $display("FAIL byte_unsigned got %h exp 00000080", d); end
    access(1'b0, 3'b000, 9'h010, 32'h0, v, d, e);
    checks++; if (d !== 32'h80223344) begin errors++; $display("FAIL byte_word_view got %h exp 80223344", d); end
  endtask

  task automatic test_half();
    logic v, e; logic [31:0] d;
    access(1'b1, 3'b011, 9'h012, 32'h0000BEEF, v, d, e);
    checks++; if ({v, e} !== 2'b10) begin errors++; $display("FAIL half_store got v=%b e=%b exp v=1 e=0", v, e); end
    access(1'b0, 3'b011, 9'h012, 32'h0, v, d, e);
    checks++; if (d !== 32'hFFFFBEEF) begin errors++; $display("FAIL half_signed got %h exp ffffbeef", d); end
    access(1'b0, 3'b100, 9'h012, 32'h0, v, d, e);
    checks++; if (d !== 32'h0000BEEF) begin errors++; $display("FAIL half_unsigned got %h exp 0000beef", d); end
    access(1'b0, 3'b011, 9'h010, 32'h0, v, d, e);
    checks++; if (d !== 32'h00003344) begin errors++; $display("FAIL half_low got %h exp 00003344", d); end
    access(1'b0, 3'b000, 9'h010, 32'h0, v, d, e);
    checks++; if (d !== 32'hBEEF3344) begin errors++; $display("FAIL half_word_view got %h exp beef3344", d); end
  endtask

  task automatic test_misalign();
    logic v, e; logic [31:0] d;
    access(1'b1, 3'b000, 9'h020, 32'hCAFEF00D, v, d, e);
    access(1'b1, 3'b000, 9'h021, 32'hDEADBEEF, v, d, e);
    checks++; if ({v, e, d} !== {2'b11, 32'h0}) begin errors++; $display("FAIL mis_word_store got v=%b e=%b d=%h exp v=1 e=1 d=0", v, e, d); end
    access(1'b0, 3'b000, 9'h020, 32'h0, v, d, e);
    checks++; if ({e, d} !== {1'b0, 32'hCAFEF00D}) begin errors++; $display("FAIL mis_unchanged got e=%b d=%h exp cafef00d", e, d); end
    access(1'b0, 3'b011, 9'h011, 32'h0, v, d, e);
    checks++; if ({e, d} !== {1'b1, 32'h0}) begin errors++; $display("FAIL mis_half_load got e=%b d=%h exp e=1 d=0", e, d); end
    access(1'b0, 3'b111, 9'h022, 32'h0, v, d, e);
    checks++; if ({e, d} !== {1'b1, 32'h0}) begin errors++; $display("FAIL mis_other_op got e=%b d=%h exp e=1 d=0", e, d); end
    access(1'b1, 3'b001, 9'h021, 32'hAABBCC77, v, d, e);
    access(1'b0, 3'b000, 9'h020, 32'h0, v, d, e);
    checks++; if (d !== 32'hCAFE770D) begin errors++; $display("FAIL byte_lane1 got %h exp cafe770d", d); end
  endtask

  task automatic test_backpressure();
    @(negedge clk); rsp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    req_we = 1'b0; req_op = 3'b000; req_addr = 9'h010; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hBEEF3344}) begin errors++; $display("FAIL bp_first got v=%b d=%h exp beef3344", rsp_valid, rsp_rdata); end
    req_addr = 9'h020;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({req_ready, rsp_valid, rsp_rdata} !== {2'b01, 32'hBEEF3344}) begin
        errors++; $display("FAIL bp_hold%0d got rdy=%b v=%b d=%h exp rdy=0 v=1 d=beef3344", i, req_ready, rsp_valid, rsp_rdata);
      end
    end
    @(negedge clk); rsp_ready = 1'b1; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb got %b exp 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hCAFE770D}) begin errors++; $display("FAIL bp_next got v=%b d=%h exp cafe770d", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    logic        we_t [4];
    logic [2:0]  op_t_ [4];
    logic [8:0]  ad_t [4];
    logic [31:0] exp_t [4];
    we_t[0] = 1; op_t_[0] = 3'b000; ad_t[0] = 9'h030; exp_t[0] = 32'h0;
    we_t[1] = 0; op_t_[1] = 3'b000; ad_t[1] = 9'h030; exp_t[1] = 32'h01020304;
    we_t[2] = 0; op_t_[2] = 3'b010; ad_t[2] = 9'h031; exp_t[2] = 32'h00000003;
    we_t[3] = 0; op_t_[3] = 3'b011; ad_t[3] = 9'h032; exp_t[3] = 32'h00000102;
    @(negedge clk); rsp_ready = 1'b1; req_wdata = 32'h01020304; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_we = we_t[i]; req_op = op_t_[i]; req_addr = ad_t[i];
      @(posedge clk); #1;
      checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, exp_t[i]}) begin
        errors++; $display("FAIL b2b%0d got v=%b e=%b d=%h exp %h", i, rsp_valid, rsp_err, rsp_rdata, exp_t[i]);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic v, e; logic [31:0] d;
    @(negedge clk); rsp_ready = 1'b1;
    @(negedge clk);
    req_we = 1'b0; req_op = 3'b011; req_addr = 9'h011; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;
    #2;
    checks++; if ({rsp_valid, rsp_err} !== 2'b11) begin errors++; $display("FAIL mid_pending got v=%b e=%b exp 11", rsp_valid, rsp_err); end
    rstn = 1'b0; #1;
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b00, 32'h0}) begin
      errors++; $display("FAIL mid_async got v=%b e=%b d=%h exp all 0", rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk); @(negedge clk); #2 rstn = 1'b1; rsp_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_discard got %b exp 0", rsp_valid); end
    access(1'b0, 3'b000, 9'h030, 32'h0, v, d, e);
    checks++; if ({v, d} !== {1'b1, 32'h01020304}) begin errors++; $display("FAIL mid_keep30 got v=%b d=%h exp 01020304", v, d); end
    access(1'b0, 3'b000, 9'h010, 32'h0, v, d, e);
    checks++; if ({v, d} !== {1'b1, 32'hBEEF3344}) begin errors++; $display("FAIL mid_keep10 got v=%b d=%h exp beef3344", v, d); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout reached without finishing, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dm_pipe.md
DM_PIPE -- requirements
Module: dm_pipe

Interface
REQ-001 The block SHALL have parameter DEPTH, default 128, meaning number of 32-bit words (power of two, 16..4096).
REQ-002 The block SHALL have parameter AW, default $clog2(DEPTH)+2, meaning width of the byte address.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1, meaning the asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1, meaning a request is presented.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the block accepts the request this cycle.
REQ-007 The block SHALL have port req_we, input, 1, meaning 1 = store, 0 = load.
REQ-008 The block SHALL have port req_op, input, 3, with these encodings: 000 word; 001 byte signed; 010 byte unsigned; 011 half signed; 100 half unsigned. Any other value is treated as word.
REQ-009 The block SHALL have port req_addr, input, AW, meaning the byte address.
REQ-010 The block SHALL have port req_wdata, input, 32, meaning store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1, meaning a response is held.
REQ-012 The block SHALL have port rsp_ready, input, 1, meaning the consumer takes the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32, meaning load result, which is 0 for stores and errors.
REQ-014 The block SHALL have port rsp_err, output, 1, meaning the access was misaligned.

Function
REQ-015 Request acceptance SHALL occur on a rising edge where req_valid and req_ready are both 1.
REQ-016 req_ready SHALL equal (!rsp_valid || rsp_ready), combinationally.
REQ-017 The block SHALL hold one response: an accept loads it on the next edge, and it is held stable until rsp_valid && rsp_ready.
REQ-018 Load latency SHALL be exactly 1 cycle from accept to rsp_valid. Back-to-back accepts SHALL give one response per cycle while rsp_ready=1.
REQ-019 The word index SHALL be req_addr[AW-1:2] and the byte lane SHALL be req_addr[1:0].
REQ-020 A byte store SHALL write only lane req_addr[1:0] with wdata[7:0].
REQ-021 A half store SHALL write lanes {1,0} or {3,2} with wdata[15:0].
REQ-022 A word store SHALL write all four lanes.
REQ-023 A store SHALL write the array on its accept edge and produce a response with rdata=0 and err=0.
REQ-024 A load SHALL extract the addressed byte or half and sign-extend (signed ops) or zero-extend (unsigned ops) it to 32 bits. The extension SHALL be to full 32 bits for halves; 16-bit extension is prohibited.
REQ-025 A half access with req_addr[0]=1, or a word access with req_addr[1:0]!=0, SHALL be treated as misaligned: no array write, rsp_err=1, rsp_rdata=0.
REQ-026 A load accepted on the edge after a store to the same word SHALL return the post-store data, with no forwarding hazard.
REQ-027 A request held while req_ready=0 SHALL not be accepted. The requester keeps all request fields stable.
REQ-028 The block SHALL produce no simulation $display output.

Reset
REQ-029 While rstn=0, the block SHALL force rsp_valid=0, rsp_err=0 and rsp_rdata=0 asynchronously.
REQ-030 Array contents SHALL not be reset or altered by rstn.
REQ-031 A response pending at reset assertion SHALL be discarded.
REQ-032 A request on the edge where rstn deasserts SHALL not be accepted. The first accept can occur on the following edge.

Structure
REQ-033 A shared package dm_pkg SHALL hold the req_op encodings (OP_W, OP_B, OP_BU, OP_H, OP_HU) and the default DEPTH.
REQ-034 One sub-module, dm_lane_fmt, SHALL be used. It is combinational and does the following:
- load lane select and sign/zero extension
- store byte-enable generation and data replication
- misalignment detection
REQ-035 The array SHALL be inferable as a synchronous-write, registered-read RAM with per-byte write enables.

Verification
REQ-036 Test: word store 0x11223344 @0x10, then word load @0x10. Required response: rdata=0x11223344, err=0, one cycle after accept.
REQ-037 Test: byte store 0x80 @0x13, then load @0x13 with op 001 and with op 010. Required responses: 0xFFFFFF80 and 0x00000080; word @0x10 reads 0x80223344.
REQ-038 Test: half store 0xBEEF @0x12, then half-signed load @0x12, then word load @0x10. Required responses: 0xFFFFBEEF and 0xBEEF3344.
REQ-039 Test: word store 0xDEADBEEF @0x21 (misaligned). Required response: rsp_err=1, rdata=0; word @0x20 unchanged.
REQ-040 Test: hold rsp_ready=0 for 3 cycles with req_valid=1. Required behaviour: req_ready=0 and the response is held stable; on rsp_ready=1 the next request is accepted the same cycle.
REQ-041 Test: assert rstn=0 mid-stream with rsp_valid=1. Required behaviour: rsp_valid drops immediately; after release, earlier stored data is still readable.
